// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, FSM encoding and pattern decode for seg7_monitor
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Returns {is_digit, value}; blank and unknown patterns both give is_digit=0.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            SEG_0:   res = {1'b1, 4'h0};
            SEG_1:   res = {1'b1, 4'h1};
            SEG_2:   res = {1'b1, 4'h2};
            SEG_3:   res = {1'b1, 4'h3};
            SEG_4:   res = {1'b1, 4'h4};
            SEG_5:   res = {1'b1, 4'h5};
            SEG_6:   res = {1'b1, 4'h6};
            SEG_7:   res = {1'b1, 4'h7};
            SEG_8:   res = {1'b1, 4'h8};
            SEG_9:   res = {1'b1, 4'h9};
            SEG_A:   res = {1'b1, 4'hA};
            SEG_B:   res = {1'b1, 4'hB};
            SEG_C:   res = {1'b1, 4'hC};
            SEG_D:   res = {1'b1, 4'hD};
            SEG_E:   res = {1'b1, 4'hE};
            SEG_F:   res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_monitor_if.sv
// rtl/seg7_monitor_if.sv - seven-segment bus lines A..G (A top, G middle)
interface seg7_monitor_if;
    logic A;
    logic B;
    logic C;
    logic D;
    logic E;
    logic F;
    logic G;

    modport master (output A, B, C, D, E, F, G);
    modport slave  (input  A, B, C, D, E, F, G);
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 7-segment pattern to {is_digit, value} lookup
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic       o_is_digit,
    output logic [3:0] o_val
);

    logic [4:0] w_dec;

    assign w_dec      = seg_decode(i_pat);
    assign o_is_digit = w_dec[4];
    assign o_val      = w_dec[3:0];

endmodule

// File: rtl/seg7_monitor.sv
// rtl/seg7_monitor.sv - seven-segment bus checker: debounce, decode, counter-order check, error count
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int MODULUS       = 10,
    parameter bit ALLOW_CLEAR   = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Clr,
    seg7_monitor_if.slave        seg,
    output logic [3:0]           Q,
    output logic                 valid,
    output logic                 locked,
    output logic                 new_digit,
    output logic                 bad_pattern,
    output logic                 seq_err,
    output logic [7:0]           err_cnt
);

    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [4:0] MOD_W       = 5'(MODULUS);

    logic [6:0] w_in;
    logic [6:0] r_samp;
    logic [6:0] r_stab_pat;
    logic [3:0] r_cnt;
    logic [6:0] r_last;
    logic [3:0] r_q;
    logic       r_valid;
    logic       r_new;
    logic       r_bad;
    logic       r_seq;
    logic [7:0] r_err;
    state_t     r_state;
    state_t     w_state_nxt;

    logic       w_stable;
    logic       w_is_digit;
    logic [3:0] w_dig;
    logic       w_in_range;
    logic [3:0] w_succ;
    logic       w_legal;
    logic [3:0] w_q_nxt;
    logic [6:0] w_last_nxt;
    logic       w_valid_nxt;
    logic       w_new_nxt;
    logic       w_bad_nxt;
    logic       w_seq_nxt;

    assign w_in = {seg.A, seg.B, seg.C, seg.D, seg.E, seg.F, seg.G};

    // r_stab_pat lags r_samp by one cycle so it always names the pattern r_cnt describes.
    assign w_stable = (r_cnt == STABLE_LAST);

    seg7_decode u_decode (
        .i_pat      (r_stab_pat),
        .o_is_digit (w_is_digit),
        .o_val      (w_dig)
    );

    assign w_in_range = ({1'b0, w_dig} < MOD_W);
    assign w_succ     = (({1'b0, r_q} + 5'd1) == MOD_W) ? 4'd0 : (r_q + 4'd1);
    assign w_legal    = (w_dig == w_succ) || (ALLOW_CLEAR && (w_dig == 4'd0));

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_last_nxt  = r_last;
        w_valid_nxt = r_valid;
        w_new_nxt   = 1'b0;
        w_bad_nxt   = 1'b0;
        w_seq_nxt   = 1'b0;
        if (w_stable && (r_stab_pat != SEG_BLANK)) begin
            if (!w_is_digit) begin
                w_bad_nxt   = 1'b1;
                w_state_nxt = ST_UNLOCKED;
                w_last_nxt  = SEG_BLANK;
            end else if (r_stab_pat != r_last) begin
                w_q_nxt     = w_dig;
                w_new_nxt   = 1'b1;
                w_valid_nxt = 1'b1;
                w_last_nxt  = r_stab_pat;
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_in_range) w_state_nxt = ST_LOCKED;
                        else            w_seq_nxt   = 1'b1;
                    end
                    ST_LOCKED: begin
                        if (!w_in_range) begin
                            w_seq_nxt   = 1'b1;
                            w_state_nxt = ST_UNLOCKED;
                        end else if (!w_legal) begin
                            w_seq_nxt   = 1'b1;
                        end
                    end
                    default: w_state_nxt = ST_UNLOCKED;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_samp     <= SEG_BLANK;
            r_stab_pat <= SEG_BLANK;
            r_cnt      <= 4'd0;
            r_last     <= SEG_BLANK;
            r_q        <= 4'd0;
            r_valid    <= 1'b0;
            r_new      <= 1'b0;
            r_bad      <= 1'b0;
            r_seq      <= 1'b0;
            r_err      <= 8'd0;
        end else begin
            r_samp     <= w_in;
            r_stab_pat <= r_samp;
            if (r_samp == r_stab_pat) begin
                if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
            r_last  <= w_last_nxt;
            r_q     <= w_q_nxt;
            r_valid <= w_valid_nxt;
            r_new   <= w_new_nxt;
            r_bad   <= w_bad_nxt;
            r_seq   <= w_seq_nxt;
            if ((w_bad_nxt || w_seq_nxt) && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
        end
    end

    assign Q           = r_q;
    assign valid       = r_valid;
    assign locked      = (r_state == ST_LOCKED);
    assign new_digit   = r_new;
    assign bad_pattern = r_bad;
    assign seq_err     = r_seq;
    assign err_cnt     = r_err;

endmodule

// File: tb/tb_seg7_monitor.sv
// tb/tb_seg7_monitor.sv - scoreboard bench for seg7_monitor
module tb_seg7_monitor;

    localparam int S   = 4;
    localparam int MOD = 10;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic [3:0] Q;
    logic       valid, locked, new_digit, bad_pattern, seq_err;
    logic [7:0] err_cnt;

    seg7_monitor_if bus ();

    seg7_monitor #(
        .STABLE_CYCLES (S),
        .MODULUS       (MOD),
        .ALLOW_CLEAR   (1'b1)
    ) dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .seg         (bus.slave),
        .Q           (Q),
        .valid       (valid),
        .locked      (locked),
        .new_digit   (new_digit),
        .bad_pattern (bad_pattern),
        .seq_err     (seq_err),
        .err_cnt     (err_cnt)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       nd, se, bp, vld, lk;
        logic [3:0] q;
        logic [7:0] err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [6:0] tab [16];
    logic [3:0] m_q;
    logic       m_valid, m_locked;
    logic [6:0] m_last, m_run_pat;
    int         m_err, m_run_len, m_run_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q = 4'd0; m_valid = 1'b0; m_locked = 1'b0; m_last = 7'h00; m_err = 0;
        m_run_pat = 7'h00; m_run_len = S; m_run_start = 0;
    endtask

    task automatic model_event(input logic [6:0] p, input int ev);
        int         idx;
        exp_t       e;
        logic [3:0] prevq;
        idx = -1;
        for (int i = 0; i < 16; i++) if (tab[i] == p) idx = i;
        if (p == 7'h00) return;
        e.cyc = ev; e.nd = 1'b0; e.se = 1'b0; e.bp = 1'b0;
        if (idx < 0) begin
            e.bp = 1'b1; m_locked = 1'b0; m_last = 7'h00;
        end else if (p == m_last) begin
            return;
        end else begin
            e.nd = 1'b1; m_valid = 1'b1; m_last = p; prevq = m_q; m_q = 4'(idx);
            if (!m_locked) begin
                if (idx < MOD) m_locked = 1'b1;
                else           e.se = 1'b1;
            end else if (idx >= MOD) begin
                e.se = 1'b1; m_locked = 1'b0;
            end else if (!(idx == (int'(prevq) + 1) % MOD || idx == 0)) begin
                e.se = 1'b1;
            end
        end
        if ((e.bp || e.se) && m_err != 255) m_err++;
        e.q = m_q; e.lk = m_locked; e.vld = m_valid; e.err = 8'(m_err);
        sb.push_back(e);
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        int start, old;
        {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = p;
        start = cyc + 1;
        if (p == m_run_pat) begin
            old = m_run_len;
            m_run_len += n;
            if (old < S && m_run_len >= S) model_event(p, m_run_start + S + 1);
        end else begin
            m_run_pat = p; m_run_start = start; m_run_len = n;
            if (n >= S) model_event(p, start + S + 1);
        end
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Clr = 1'b1;
        @(posedge Clk);
        #1;
        Clr = 1'b0;
        model_reset();
    endtask

    task automatic check_reset();
        check("rst_q", 32'(Q), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_new_digit", 32'(new_digit), 0);
        check("rst_bad_pattern", 32'(bad_pattern), 0);
        check("rst_seq_err", 32'(seq_err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
    endtask

    // Every output pulse must match the head of the scoreboard, including its cycle.
    always @(negedge Clk) begin
        if (!Clr && ({new_digit, seq_err, bad_pattern} !== 3'b000)) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", 32'({new_digit, seq_err, bad_pattern}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ev_cycle", 32'(cyc), 32'(e.cyc));
                check("ev_new_digit", 32'(new_digit), 32'(e.nd));
                check("ev_seq_err", 32'(seq_err), 32'(e.se));
                check("ev_bad_pattern", 32'(bad_pattern), 32'(e.bp));
                check("ev_q", 32'(Q), 32'(e.q));
                check("ev_locked", 32'(locked), 32'(e.lk));
                check("ev_valid", 32'(valid), 32'(e.vld));
                check("ev_err_cnt", 32'(err_cnt), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cycle %0d, expected finish", cyc);
        $fatal(1);
    end

    initial begin
        tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = 7'h00;
        repeat (2) @(posedge Clk);
        #1;
        Clr = 1'b0;
        model_reset();
        check_reset();

        for (int i = 0; i <= MOD; i++) hold(tab[i % MOD], 10);

        hold(7'h30, 3);
        hold(7'h7E, 10);
        hold(7'h30, 4);
        hold(7'h6D, 8);
        hold(7'h79, 8);
        hold(7'h5B, 8);
        hold(7'h7E, 8);
        hold(7'h01, 8);
        hold(7'h33, 8);
        hold(7'h77, 8);
        hold(7'h00, 8);
        check("seq_err_cnt", 32'(err_cnt), 3);
        check("seq_locked_end", 32'(locked), 0);

        hold(7'h30, 3);
        do_reset();
        check_reset();
        hold(7'h30, 3);
        hold(7'h7E, 8);
        hold(7'h00, 8);
        check("clr_q", 32'(Q), 0);
        check("clr_locked", 32'(locked), 1);

        do_reset();
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h01 : 7'h02, S);
        hold(7'h00, 8);
        check("sat_err_cnt", 32'(err_cnt), 255);
        do_reset();
        check_reset();

        hold(7'h00, 8);
        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
